float_unpack_normalize: RTL and testbench
=========================================

// Module: float_unpack_normalize
// PURPOSE
// - Registered front end for float->posit/fixed converters. Classifies an IEEE-style float
//   (zero/denormal/inf/NaN) and renormalizes denormals via leading-zero count.
// - Produces the unbiased signed exponent, the normalized fraction, and a trailing-bit/sticky
//   slice of that fraction for the downstream rounder.
// PARAMETERS
// - FLOAT_EXP     8   exponent field width (>=2)
// - FLOAT_FRAC    23  fraction field width (>=2)
// - TRAIL_START   17  MSB index of trailing-bit slice in normalized fraction; may be <TRAIL_WIDTH-1
// - TRAIL_WIDTH   2   trailing-bit slice width (>=1)
// - FTZ_DENORMAL  0   1: denormals flush (fraction forced 0, flagged denormal)
// PORTS
// - clock         in   1               rising-edge clock
// - resetn        in   1               synchronous reset, active low
// - in_valid      in   1               input sample valid
// - in_sign       in   1               float sign
// - in_exp        in   FLOAT_EXP       biased exponent field
// - in_frac       in   FLOAT_FRAC      fraction field
// - out_valid     out  1               registered in_valid
// - out_sign      out  1               registered sign (passed unchanged, incl. inf/NaN)
// - out_is_zero / out_is_denormal / out_is_inf / out_is_nan  out 1 each: classification
// - out_exp       out  SEXP_W          signed unbiased exponent, SEXP_W=FLOAT_EXP+$clog2(FLOAT_FRAC+2)
// - out_lz        out  LZ_W            clz(in_frac)+1, LZ_W=$clog2(FLOAT_FRAC+2)
// - out_frac      out  FLOAT_FRAC      normalized fraction (hidden 1 removed)
// - out_trail     out  TRAIL_WIDTH     out_frac[TRAIL_START -: TRAIL_WIDTH], indices <0 read 0
// - out_sticky    out  1               OR of out_frac[TRAIL_START-TRAIL_WIDTH:0]; 0 if range empty
// BEHAVIOUR
// - Latency 1 cycle; no backpressure. All outputs registered.
// - resetn=0 at posedge: every output <= 0. Reset beats in_valid.
// - in_valid=1: datapath regs load; in_valid=0: datapath regs hold. out_valid<=in_valid each cycle.
// - Classes (exactly one or none asserted): zero: exp==0,frac==0; denormal: exp==0,frac!=0;
//   inf: exp==all-ones,frac==0; nan: exp==all-ones,frac!=0.
// - out_lz = leading zeros of in_frac (MSB-first) + 1; frac==0 gives FLOAT_FRAC+1.
// - BIAS = 2^(FLOAT_EXP-1)-1. Normal/inf/nan/zero: out_exp = exp - BIAS (sign-extended).
// - Denormal (FTZ=0): out_exp = (1-BIAS) - out_lz; out_frac = (in_frac << out_lz) truncated.
// - Denormal (FTZ=1): out_exp = exp - BIAS (= -BIAS); out_frac = 0; out_lz still computed.
// - Otherwise out_frac = in_frac. out_trail/out_sticky always from the out_frac value being loaded.
// - No overflow possible: SEXP_W covers [1-BIAS-FLOAT_FRAC, BIAS+1].
// STRUCTURE
// - Package float_unpack_pkg: exp_bias(FLOAT_EXP), min_normal_exp(), sexp_w(), lz_w() functions.
// - Sub-module leading_zero_counter #(WIDTH, ADD_OFFSET): combinational, priority-encoded CLZ.
// - Classification, shift, part-select and sticky OR combinational; single output register stage.
// TESTING (FP32 defaults, TRAIL_START=17, TRAIL_WIDTH=2)
// - 0x3F800000 -> normal, exp 0, frac 0, lz 24, trail 00, sticky 0, out_valid one cycle later.
// - 0x00000001 -> denormal, lz 23, exp -149, frac 0; FTZ=1: frac 0, exp -127.
// - 0x00400000 -> denormal, lz 1, exp -127, frac 0; 0x00200000 -> lz 2, exp -128, frac 0.
// - 0x7F800000 -> inf; 0x7FC00000 -> nan; 0x80000000 -> zero, sign 1, exp -127.
// - 0x3F820001 -> trail 2'b10, sticky 1; 0x3F820000 -> trail 2'b10, sticky 0.
// - resetn=0 with in_valid=1 -> all outputs 0 next cycle; in_valid=0 -> data held, out_valid 0.

Source files
------------

// File: rtl/float_unpack_pkg.sv
// Shared sizing helpers for the float unpack/normalize front end.
package float_unpack_pkg;

  function automatic int exp_bias(input int unsigned float_exp);
    return (1 << (float_exp - 1)) - 1;
  endfunction

  // Unbiased exponent of the smallest normal number, also the scale of denormals.
  function automatic int min_normal_exp(input int unsigned float_exp);
    return 1 - exp_bias(float_exp);
  endfunction

  function automatic int unsigned lz_w(input int unsigned float_frac);
    return $clog2(float_frac + 2);
  endfunction

  function automatic int unsigned sexp_w(input int unsigned float_exp,
                                         input int unsigned float_frac);
    return float_exp + lz_w(float_frac);
  endfunction

endpackage

// File: rtl/leading_zero_counter.sv
// Combinational priority-encoded count of leading zeros (MSB first) plus a fixed offset.
module leading_zero_counter #(
  parameter int unsigned WIDTH      = 23,
  parameter int unsigned ADD_OFFSET = 1
) (
  input  logic [WIDTH-1:0]              in_bits,
  output logic [$clog2(WIDTH+2)-1:0]    count_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 2);

  logic [CNT_W-1:0] zeros;

  // Scanning up from the LSB lets the highest set bit win.
  always_comb begin
    zeros = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (in_bits[i]) zeros = CNT_W'(WIDTH - 1 - i);
    end
    count_c = zeros + CNT_W'(ADD_OFFSET);
  end

endmodule

// File: rtl/float_unpack_normalize.sv
// Registered float classifier/denormal renormalizer feeding float->posit/fixed converters.
module float_unpack_normalize
  import float_unpack_pkg::*;
#(
  parameter int unsigned FLOAT_EXP    = 8,
  parameter int unsigned FLOAT_FRAC   = 23,
  parameter int unsigned TRAIL_START  = 17,
  parameter int unsigned TRAIL_WIDTH  = 2,
  parameter int unsigned FTZ_DENORMAL = 0
) (
  input  logic                                        clock,
  input  logic                                        resetn,
  input  logic                                        in_valid,
  input  logic                                        in_sign,
  input  logic [FLOAT_EXP-1:0]                        in_exp,
  input  logic [FLOAT_FRAC-1:0]                       in_frac,
  output logic                                        out_valid,
  output logic                                        out_sign,
  output logic                                        out_is_zero,
  output logic                                        out_is_denormal,
  output logic                                        out_is_inf,
  output logic                                        out_is_nan,
  output logic [sexp_w(FLOAT_EXP, FLOAT_FRAC)-1:0]    out_exp,
  output logic [lz_w(FLOAT_FRAC)-1:0]                 out_lz,
  output logic [FLOAT_FRAC-1:0]                       out_frac,
  output logic [TRAIL_WIDTH-1:0]                      out_trail,
  output logic                                        out_sticky
);

  localparam int unsigned SEXP_W    = sexp_w(FLOAT_EXP, FLOAT_FRAC);
  localparam int unsigned LZ_W      = lz_w(FLOAT_FRAC);
  localparam int          BIAS      = exp_bias(FLOAT_EXP);
  localparam int          MIN_EXP   = min_normal_exp(FLOAT_EXP);
  localparam int          STICKY_HI = int'(TRAIL_START) - int'(TRAIL_WIDTH);

  logic                    exp_zero_c, exp_ones_c, frac_zero_c;
  logic                    is_zero_c, is_den_c, is_inf_c, is_nan_c;
  logic [LZ_W-1:0]         lz_c;
  logic [SEXP_W-1:0]       sexp_c;
  logic [FLOAT_FRAC-1:0]   norm_frac_c;
  logic [TRAIL_WIDTH-1:0]  trail_c;
  logic                    sticky_c;

  logic                    valid_d, valid_q;
  logic                    sign_d, sign_q;
  logic                    zero_d, zero_q;
  logic                    den_d, den_q;
  logic                    inf_d, inf_q;
  logic                    nan_d, nan_q;
  logic [SEXP_W-1:0]       exp_d, exp_q;
  logic [LZ_W-1:0]         lz_d, lz_q;
  logic [FLOAT_FRAC-1:0]   frac_d, frac_q;
  logic [TRAIL_WIDTH-1:0]  trail_d, trail_q;
  logic                    sticky_d, sticky_q;

  leading_zero_counter #(
    .WIDTH      (FLOAT_FRAC),
    .ADD_OFFSET (1)
  ) u_lzc (
    .in_bits (in_frac),
    .count_c (lz_c)
  );

  // Classification, exponent unbias and denormal renormalization.
  always_comb begin
    exp_zero_c  = (in_exp == '0);
    exp_ones_c  = &in_exp;
    frac_zero_c = (in_frac == '0);
    is_zero_c   = exp_zero_c & frac_zero_c;
    is_den_c    = exp_zero_c & ~frac_zero_c;
    is_inf_c    = exp_ones_c & frac_zero_c;
    is_nan_c    = exp_ones_c & ~frac_zero_c;

    sexp_c      = SEXP_W'(in_exp) - SEXP_W'(BIAS);
    norm_frac_c = in_frac;
    if (is_den_c) begin
      if (FTZ_DENORMAL != 0) begin
        norm_frac_c = '0;
      end else begin
        norm_frac_c = in_frac << lz_c;
        sexp_c      = SEXP_W'(MIN_EXP) - SEXP_W'(lz_c);
      end
    end

    // Zero padding below bit 0 makes slice positions under zero read as 0.
    trail_c = TRAIL_WIDTH'({norm_frac_c, TRAIL_WIDTH'(0)} >> (TRAIL_START + 1));
  end

  if (STICKY_HI >= 0) begin : g_sticky
    assign sticky_c = |norm_frac_c[STICKY_HI:0];
  end else begin : g_no_sticky
    assign sticky_c = 1'b0;
  end

  // Datapath loads only on valid input; valid itself follows in_valid every cycle.
  always_comb begin
    valid_d  = in_valid;
    sign_d   = sign_q;
    zero_d   = zero_q;
    den_d    = den_q;
    inf_d    = inf_q;
    nan_d    = nan_q;
    exp_d    = exp_q;
    lz_d     = lz_q;
    frac_d   = frac_q;
    trail_d  = trail_q;
    sticky_d = sticky_q;
    if (in_valid) begin
      sign_d   = in_sign;
      zero_d   = is_zero_c;
      den_d    = is_den_c;
      inf_d    = is_inf_c;
      nan_d    = is_nan_c;
      exp_d    = sexp_c;
      lz_d     = lz_c;
      frac_d   = norm_frac_c;
      trail_d  = trail_c;
      sticky_d = sticky_c;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid_q  <= 1'b0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      den_q    <= 1'b0;
      inf_q    <= 1'b0;
      nan_q    <= 1'b0;
      exp_q    <= '0;
      lz_q     <= '0;
      frac_q   <= '0;
      trail_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      den_q    <= den_d;
      inf_q    <= inf_d;
      nan_q    <= nan_d;
      exp_q    <= exp_d;
      lz_q     <= lz_d;
      frac_q   <= frac_d;
      trail_q  <= trail_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_sign        = sign_q;
  assign out_is_zero     = zero_q;
  assign out_is_denormal = den_q;
  assign out_is_inf      = inf_q;
  assign out_is_nan      = nan_q;
  assign out_exp         = exp_q;
  assign out_lz          = lz_q;
  assign out_frac        = frac_q;
  assign out_trail       = trail_q;
  assign out_sticky      = sticky_q;

endmodule

// File: tb/tb_float_unpack_normalize.sv
// Randomized self-checking bench for float_unpack_normalize (FP32, with and without flush-to-zero).
module tb_float_unpack_normalize;

  typedef struct packed {
    logic        v, s, z, d, i, n;
    logic [12:0] e;
    logic [4:0]  lz;
    logic [22:0] f;
    logic [1:0]  t;
    logic        st;
  } res_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [22:0] in_frac;

  res_t got0, got1, exp0, exp1;

  int total = 0;
  int bad   = 0;

  float_unpack_normalize #(.FTZ_DENORMAL(0)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_sign(in_sign),
    .in_exp(in_exp), .in_frac(in_frac),
    .out_valid(got0.v), .out_sign(got0.s), .out_is_zero(got0.z),
    .out_is_denormal(got0.d), .out_is_inf(got0.i), .out_is_nan(got0.n),
    .out_exp(got0.e), .out_lz(got0.lz), .out_frac(got0.f),
    .out_trail(got0.t), .out_sticky(got0.st)
  );

  float_unpack_normalize #(.FTZ_DENORMAL(1)) dut_ftz (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_sign(in_sign),
    .in_exp(in_exp), .in_frac(in_frac),
    .out_valid(got1.v), .out_sign(got1.s), .out_is_zero(got1.z),
    .out_is_denormal(got1.d), .out_is_inf(got1.i), .out_is_nan(got1.n),
    .out_exp(got1.e), .out_lz(got1.lz), .out_frac(got1.f),
    .out_trail(got1.t), .out_sticky(got1.st)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Reference: value-level decode of an FP32 word.
  function automatic res_t ref_unpack(input logic [31:0] w, input bit ftz);
    res_t   r;
    int     ef, e, lz;
    longint fr, nf, tmp;
    ef = int'(w[30:23]);
    fr = longint'(w[22:0]);
    tmp = fr;
    lz = 24;
    while (tmp != 0) begin
      tmp = tmp >> 1;
      lz--;
    end
    r    = '0;
    r.v  = 1'b1;
    r.s  = w[31];
    r.z  = (ef == 0)   && (fr == 0);
    r.d  = (ef == 0)   && (fr != 0);
    r.i  = (ef == 255) && (fr == 0);
    r.n  = (ef == 255) && (fr != 0);
    e    = ef - 127;
    nf   = fr;
    if (r.d) begin
      if (ftz) nf = 0;
      else begin
        nf = (fr << lz) % (64'd1 << 23);
        e  = -126 - lz;
      end
    end
    r.e  = 13'(e);
    r.lz = 5'(lz);
    r.f  = 23'(nf);
    r.t  = 2'((nf >> 16) % 4);
    r.st = (nf % 65536) != 0;
    return r;
  endfunction

  task automatic cmp(input string who, input res_t g, input res_t w);
    check_val({who, "_valid"},  longint'(g.v),  longint'(w.v));
    check_val({who, "_sign"},   longint'(g.s),  longint'(w.s));
    check_val({who, "_zero"},   longint'(g.z),  longint'(w.z));
    check_val({who, "_den"},    longint'(g.d),  longint'(w.d));
    check_val({who, "_inf"},    longint'(g.i),  longint'(w.i));
    check_val({who, "_nan"},    longint'(g.n),  longint'(w.n));
    check_val({who, "_exp"},    longint'($signed(g.e)), longint'($signed(w.e)));
    check_val({who, "_lz"},     longint'(g.lz), longint'(w.lz));
    check_val({who, "_frac"},   longint'(g.f),  longint'(w.f));
    check_val({who, "_trail"},  longint'(g.t),  longint'(w.t));
    check_val({who, "_sticky"}, longint'(g.st), longint'(w.st));
  endtask

  // One clock: drive, update the expected registers, then compare both instances.
  task automatic step(input logic rn, input logic v, input logic [31:0] w);
    res_t r0, r1;
    @(negedge clock);
    resetn   = rn;
    in_valid = v;
    in_sign  = w[31];
    in_exp   = w[30:23];
    in_frac  = w[22:0];
    r0 = ref_unpack(w, 1'b0);
    r1 = ref_unpack(w, 1'b1);
    @(posedge clock);
    if (!rn) begin
      exp0 = '0;
      exp1 = '0;
    end else if (v) begin
      exp0 = r0;
      exp1 = r1;
    end else begin
      exp0.v = 1'b0;
      exp1.v = 1'b0;
    end
    #1;
    cmp("nrm", got0, exp0);
    cmp("ftz", got1, exp1);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: w[30:23] = 8'h00;
      1: w[30:23] = 8'hFF;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) w[22:0] = 23'h0;
    else if ($urandom_range(0, 3) == 0) w[22:0] = w[22:0] >> $urandom_range(0, 22);
    return w;
  endfunction

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_frac = '0;
    exp0 = '0; exp1 = '0;

    // Reset beats a valid input.
    step(1'b0, 1'b1, 32'h3F820001);
    check_val("rst_all", longint'(got0 == '0), 1);

    step(1'b1, 1'b1, 32'h3F800000);
    check_val("one_lz", longint'(got0.lz), 24);
    check_val("one_exp", longint'($signed(got0.e)), 0);
    step(1'b1, 1'b1, 32'h00000001);
    check_val("den1_exp", longint'($signed(got0.e)), -149);
    check_val("den1_lz", longint'(got0.lz), 23);
    check_val("den1_ftz_exp", longint'($signed(got1.e)), -127);
    step(1'b1, 1'b1, 32'h00400000);
    check_val("den22_exp", longint'($signed(got0.e)), -127);
    step(1'b1, 1'b1, 32'h00200000);
    check_val("den21_exp", longint'($signed(got0.e)), -128);
    check_val("den21_lz", longint'(got0.lz), 2);
    step(1'b1, 1'b1, 32'h7F800000);
    check_val("inf_flag", longint'(got0.i), 1);
    step(1'b1, 1'b1, 32'h7FC00000);
    check_val("nan_flag", longint'(got0.n), 1);
    step(1'b1, 1'b1, 32'h80000000);
    check_val("negzero_exp", longint'($signed(got0.e)), -127);
    check_val("negzero_sign", longint'(got0.s), 1);
    step(1'b1, 1'b1, 32'h3F820001);
    check_val("trail_a", longint'(got0.t), 2);
    check_val("sticky_a", longint'(got0.st), 1);
    step(1'b1, 1'b1, 32'h3F820000);
    check_val("trail_b", longint'(got0.t), 2);
    check_val("sticky_b", longint'(got0.st), 0);
    // Hold while idle.
    step(1'b1, 1'b0, 32'h00000001);
    check_val("hold_trail", longint'(got0.t), 2);
    check_val("hold_valid", longint'(got0.v), 0);

    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), rand_word());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
